// File: rtl/ef_i2s_capture_ctrl.sv
// I2S capture sequencer: flushes the receive FIFO, waits for a trigger, then
// streams capture_len FIFO words through a one-entry output register.
module ef_i2s_capture_ctrl #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    trig_mode,
  input  logic [CW-1:0] capture_len,
  input  logic          vad_flag,
  input  logic          avg_flag,
  output logic          i2s_en,
  output logic          fifo_flush,
  output logic          fifo_rd,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [31:0]   fifo_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_ARM     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   m_data_q, m_data_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          trig_hit, pop, last_pop;

  always_comb begin
    case (trig_mode)
      2'b01:   trig_hit = vad_flag;
      2'b10:   trig_hit = avg_flag;
      default: trig_hit = 1'b1;
    endcase
  end

  // Counter saturates so continuous mode can never alias back onto capture_len.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign last_pop = (capture_len != '0) && (cnt_inc == capture_len);

  // On the trigger cycle the head word belongs to the capture, so ARM leaves it.
  always_comb begin
    fifo_rd = 1'b0;
    case (state_q)
      S_ARM:     fifo_rd = !fifo_empty && !trig_hit;
      S_CAPTURE: fifo_rd = !fifo_empty && (!m_valid_q || m_ready);
      default:   fifo_rd = 1'b0;
    endcase
    if (stop || rst) fifo_rd = 1'b0;
  end

  assign pop = fifo_rd && (state_q == S_CAPTURE);

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_FLUSH;
          overrun_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_FLUSH: state_d = S_ARM;
      S_ARM: begin
        if (trig_hit) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (fifo_full) overrun_d = 1'b1;
        if (pop) begin
          m_data_d  = fifo_rdata;
          m_valid_d = 1'b1;
          m_last_d  = last_pop;
          cnt_d     = cnt_inc;
          if (last_pop) state_d = S_DRAIN;
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      S_DRAIN: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign i2s_en     = (state_q == S_FLUSH) || (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign fifo_flush = (state_q == S_FLUSH);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_data     = m_data_q;
  assign overrun    = overrun_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ef_i2s_capture_ctrl.sv
// Directed/random bench for ef_i2s_capture_ctrl: a queue-style FIFO model feeds
// the DUT and the accepted stream is compared with the words pushed after trigger.
module tb_ef_i2s_capture_ctrl;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, vad_flag, avg_flag, fifo_full, m_ready;
  logic [1:0]    trig_mode;
  logic [CW-1:0] capture_len;
  logic          i2s_en, fifo_flush, fifo_rd, fifo_empty, m_valid, m_last;
  logic          busy, done, overrun;
  logic [31:0]   fifo_rdata, m_data;
  logic [2:0]    state;

  always #5 clk = ~clk;

  ef_i2s_capture_ctrl #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trig_mode(trig_mode),
    .capture_len(capture_len), .vad_flag(vad_flag), .avg_flag(avg_flag),
    .i2s_en(i2s_en), .fifo_flush(fifo_flush), .fifo_rd(fifo_rd),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rdata(fifo_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .overrun(overrun), .state(state)
  );

  int vectors = 0;
  int errors  = 0;

  // FIFO model: first-word-fall-through buffer, flush drops everything queued.
  logic [31:0] mem [0:1023];
  logic [15:0] wp = '0;
  logic [15:0] rp = '0;
  assign fifo_empty = (wp == rp);
  assign fifo_rdata = mem[rp[9:0]];
  always @(posedge clk) begin
    if (fifo_flush)   rp <= wp;
    else if (fifo_rd) rp <= rp + 16'd1;
  end

  logic [31:0] obs_d[$];
  logic        obs_l[$];
  logic [31:0] cap[$];
  int          done_cnt = 0;
  int          last_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one step before the rising edge, after the negedge stimulus settled.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (m_valid && m_ready) begin
        obs_d.push_back(m_data);
        obs_l.push_back(m_last);
      end
      if (done) done_cnt++;
      if (m_last) last_cnt++;
      chk("rd_when_empty", {31'd0, fifo_rd && fifo_empty}, 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w, input bit captured);
    mem[wp[9:0]] = w;
    wp = wp + 16'd1;
    if (captured) cap.push_back(w);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, s});
  endtask

  task automatic start_cap(input logic [1:0] mode, input logic [CW-1:0] len);
    trig_mode   = mode;
    capture_len = len;
    obs_d.delete();
    obs_l.delete();
    cap.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("flush_state", {29'd0, state}, 32'd1);
    chk("flush_outs", {30'd0, fifo_flush, i2s_en}, 32'd3);
    tick();
    chk("arm_state", {29'd0, state}, 32'd2);
  endtask

  // Reference: first len post-trigger words (all of them when len is 0), last on len-th.
  task automatic check_stream(input string tag, input int len);
    int n   = (len == 0 || len > cap.size()) ? cap.size() : len;
    int bad = 0;
    chk({tag, "_count"}, obs_d.size(), n);
    for (int i = 0; i < obs_d.size() && i < n; i++) begin
      if (obs_d[i] !== cap[i]) bad++;
      if (obs_l[i] !== (len != 0 && i == len - 1)) bad++;
    end
    chk({tag, "_words"}, bad, 32'd0);
  endtask

  initial begin
    int dc, lc, n;
    logic [31:0] d0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; vad_flag = 1'b0; avg_flag = 1'b0;
    fifo_full = 1'b0; m_ready = 1'b1; trig_mode = 2'b00; capture_len = '0;
    tick(); tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_flags", {24'd0, i2s_en, fifo_flush, fifo_rd, m_valid, m_last, done, overrun, busy}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    rst = 1'b0;
    tick();

    // Immediate trigger, 4 of 5 words streamed.
    dc = done_cnt;
    start_cap(2'b00, 8'd4);
    for (int i = 0; i < 5; i++) push($urandom(), 1'b1);
    wait_state(3'd5, 40, "t1_reach_done");
    chk("t1_done_hi", {31'd0, done}, 32'd1);
    tick();
    chk("t1_idle", {29'd0, state}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    check_stream("t1", 4);
    chk("t1_e_left", 32'(wp - rp), 32'd1);
    chk("t1_done_pulses", done_cnt - dc, 32'd1);

    // VAD trigger: pre-trigger words discarded in ARM.
    start_cap(2'b01, 8'd3);
    for (int i = 0; i < 3; i++) begin
      push($urandom(), 1'b0);
      tick();
    end
    tick(); tick();
    chk("t2_arm_hold", {29'd0, state}, 32'd2);
    chk("t2_discarded", 32'(wp - rp), 32'd0);
    chk("t2_no_stream", obs_d.size(), 32'd0);
    vad_flag = 1'b1;
    for (int i = 0; i < 3; i++) push($urandom(), 1'b1);
    tick();
    vad_flag = 1'b0;
    chk("t2_capture", {29'd0, state}, 32'd3);
    wait_state(3'd5, 40, "t2_reach_done");
    tick();
    check_stream("t2", 3);

    // Backpressure stall of 10 cycles, then random m_ready.
    start_cap(2'b11, 8'd8);
    for (int i = 0; i < 8; i++) push($urandom(), 1'b1);
    tick(); tick(); tick(); tick();
    m_ready = 1'b0;
    #1 d0 = m_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_data_hold", m_data, d0);
      chk("t3_no_rd", {31'd0, fifo_rd}, 32'd0);
      chk("t3_valid_hold", {31'd0, m_valid}, 32'd1);
    end
    n = 0;
    while (state !== 3'd5 && n < 300) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    chk("t3_reach_done", {29'd0, state}, 32'd5);
    tick();
    check_stream("t3", 8);

    // Stop while a word is held in the output register.
    dc = done_cnt;
    start_cap(2'b00, 8'd8);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push($urandom(), 1'b1);
    n = 0;
    while (m_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("t4_valid_before", {31'd0, m_valid}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_state", {29'd0, state}, 32'd0);
    chk("t4_outs", {29'd0, m_valid, i2s_en, m_last}, 32'd0);
    tick(); tick(); tick();
    chk("t4_no_done", done_cnt - dc, 32'd0);
    m_ready = 1'b1;

    // Energy trigger with vad ignored; overrun sticky from CAPTURE only.
    start_cap(2'b10, 8'd4);
    vad_flag = 1'b1;
    push($urandom(), 1'b0);
    push($urandom(), 1'b0);
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    tick(); tick();
    chk("t5_arm_hold", {29'd0, state}, 32'd2);
    chk("t5_no_ovr_arm", {31'd0, overrun}, 32'd0);
    chk("t5_discarded", 32'(wp - rp), 32'd0);
    avg_flag = 1'b1;
    for (int i = 0; i < 4; i++) push($urandom(), 1'b1);
    tick();
    avg_flag = 1'b0;
    vad_flag = 1'b0;
    chk("t5_capture", {29'd0, state}, 32'd3);
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    chk("t5_ovr_set", {31'd0, overrun}, 32'd1);
    wait_state(3'd5, 40, "t5_reach_done");
    chk("t5_ovr_done", {31'd0, overrun}, 32'd1);
    tick();
    chk("t5_ovr_idle", {29'd0, state, overrun}, 32'd1);
    check_stream("t5", 4);

    // Continuous mode, 300 words through an 8-bit counter; next start clears overrun.
    dc = done_cnt;
    lc = last_cnt;
    start_cap(2'b00, 8'd0);
    chk("t6_ovr_clear", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 300; i++) push($urandom(), 1'b1);
    n = 0;
    while (obs_d.size() < 300 && n < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    tick(); tick();
    chk("t6_still_cap", {29'd0, state}, 32'd3);
    chk("t6_no_last", last_cnt - lc, 32'd0);
    check_stream("t6", 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_stopped", {29'd0, state}, 32'd0);
    tick();
    chk("t6_no_done", done_cnt - dc, 32'd0);

    // Reset mid-capture dominates stop/start and drops the held word.
    start_cap(2'b00, 8'd4);
    m_ready = 1'b0;
    push(32'hA5A5_0001, 1'b1);
    push(32'hA5A5_0002, 1'b1);
    tick(); tick(); tick();
    chk("t7_held", m_data, 32'hA5A5_0001);
    rst = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; stop = 1'b0; start = 1'b0;
    chk("t7_state", {29'd0, state}, 32'd0);
    chk("t7_flags", {29'd0, m_valid, m_last, busy}, 32'd0);
    chk("t7_data", m_data, 32'd0);
    m_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
